// File: rtl/dispatch_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dispatch_ctrl_pkg: shared constants and decoded-lane payload type         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package dispatch_ctrl_pkg;

    localparam int DEC_WIDTH = 4;
    localparam int NUM_DQ    = 4;
    localparam int FREE_W    = 3;
    localparam int QID_W     = 2;

    typedef struct packed {
        logic [15:0]      pc;
        logic [7:0]       uop;
        logic             need_serialize;
        logic [QID_W-1:0] dispQue_id;
    } decInfo_t;

endpackage
`default_nettype wire

// File: rtl/dq_prefix_fit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dq_prefix_fit: longest valid lane prefix fitting per-queue free space     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module dq_prefix_fit #(
    parameter int DECWIDTH = 4,
    parameter int NUMDQ    = 4,
    parameter int FREEW    = 3,
    parameter int QIDW     = $clog2(NUMDQ)
) (
    input  logic [DECWIDTH-1:0]           vld,
    input  logic [DECWIDTH-1:0][QIDW-1:0] qid,
    input  logic [NUMDQ-1:0][FREEW-1:0]   free,
    output logic [FREEW-1:0]              cnt
);

    logic [FREEW-1:0] used [NUMDQ];
    logic             stop;

    // count >= free is the same test as count+1 > free without widening
    always_comb begin
        cnt  = '0;
        stop = 1'b0;
        for (int q = 0; q < NUMDQ; q++) begin
            used[q] = '0;
        end
        for (int i = 0; i < DECWIDTH; i++) begin
            if (!stop) begin
                if (!vld[i] || (used[qid[i]] >= free[qid[i]])) begin
                    stop = 1'b1;
                end else begin
                    used[qid[i]] = used[qid[i]] + FREEW'(1);
                    cnt          = cnt + FREEW'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dispatch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dispatch_ctrl: steers decode lanes into dispatch queues, serializing ops  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module dispatch_ctrl
    import dispatch_ctrl_pkg::*;
#(
    parameter int DECWIDTH = DEC_WIDTH,
    parameter int NUMDQ    = NUM_DQ,
    parameter int FREEW    = FREE_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_squash,
    input  logic                         i_stall,
    input  logic [DECWIDTH-1:0]          i_dec_vld,
    input  decInfo_t [DECWIDTH-1:0]      i_dec_info,
    output logic [FREEW-1:0]             o_acc_cnt,
    input  logic [NUMDQ-1:0][FREEW-1:0]  i_dq_free,
    input  logic                         i_rob_empty,
    output logic [DECWIDTH-1:0]          o_disp_vld,
    output decInfo_t [DECWIDTH-1:0]      o_disp_info,
    output logic                         o_serializing
);

    localparam int QIDW = $clog2(NUMDQ);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_WAIT   = 2'd3
    } serState_t;

    serState_t                     state;
    serState_t                     state_nxt;
    logic [DECWIDTH-1:0]           ser_lane;
    logic [DECWIDTH-1:0]           fit_vld;
    logic [DECWIDTH-1:0]           acc_mask;
    logic [DECWIDTH-1:0][QIDW-1:0] lane_qid;
    logic [FREEW-1:0]              fit_cnt;
    logic                          disp_idle;

    // Serialize lanes act as a prefix terminator, except in ISSUE where lane0 alone goes
    always_comb begin
        for (int i = 0; i < DECWIDTH; i++) begin
            ser_lane[i] = i_dec_info[i].need_serialize;
            lane_qid[i] = i_dec_info[i].dispQue_id;
        end
        if (state == ST_ISSUE) begin
            fit_vld = {{(DECWIDTH-1){1'b0}}, i_dec_vld[0]};
        end else begin
            fit_vld = i_dec_vld & ~ser_lane;
        end
    end

    dq_prefix_fit #(
        .DECWIDTH (DECWIDTH),
        .NUMDQ    (NUMDQ),
        .FREEW    (FREEW),
        .QIDW     (QIDW)
    ) u_fit (
        .vld  (fit_vld),
        .qid  (lane_qid),
        .free (i_dq_free),
        .cnt  (fit_cnt)
    );

    assign disp_idle     = ~|o_disp_vld;
    assign o_serializing = (state != ST_NORMAL);

    always_comb begin
        state_nxt = state;
        o_acc_cnt = '0;
        unique case (state)
            ST_NORMAL: begin
                if (i_dec_vld[0] && ser_lane[0]) begin
                    state_nxt = ST_DRAIN;
                end else begin
                    o_acc_cnt = fit_cnt;
                end
            end
            ST_DRAIN: begin
                if (i_rob_empty && disp_idle) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if ((fit_cnt != '0) && !i_stall) begin
                    o_acc_cnt = fit_cnt;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (disp_idle && i_rob_empty) begin
                    state_nxt = ST_NORMAL;
                end
            end
        endcase
        if (i_stall) begin
            o_acc_cnt = '0;
        end
        if (rst || i_squash) begin
            o_acc_cnt = '0;
            state_nxt = ST_NORMAL;
        end
    end

    always_comb begin
        for (int i = 0; i < DECWIDTH; i++) begin
            acc_mask[i] = (FREEW'(i) < o_acc_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_squash) begin
            state       <= ST_NORMAL;
            o_disp_vld  <= '0;
            o_disp_info <= '0;
        end else begin
            state      <= state_nxt;
            o_disp_vld <= acc_mask;
            for (int i = 0; i < DECWIDTH; i++) begin
                o_disp_info[i] <= acc_mask[i] ? i_dec_info[i] : '0;
            end
        end
    end

endmodule
`default_nettype wire
